// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised pipeline boundary register with stall/bubble/flush handling and event counters
module pipe_stage_reg #(
    parameter int                       DATA_W  = 32,
    parameter int                       LANES   = 4,
    parameter int                       STALL_W = 6,
    parameter int                       STAGE   = 2,
    parameter logic [DATA_W*LANES-1:0]  BUBBLE  = '0,
    parameter int                       CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [DATA_W*LANES-1:0]   in_data,
    input  logic                      in_next_in_delayslot,
    output logic                      out_valid,
    output logic [DATA_W*LANES-1:0]   out_data,
    output logic                      out_is_in_delayslot,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          bubble_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
        $error("pipe_stage_reg: STAGE must lie in 0..STALL_W-2");
    end

    typedef enum logic [1:0] {
        OP_FLUSH,
        OP_BUBBLE,
        OP_PASS,
        OP_HOLD
    } op_e;

    op_e op;

    logic up_stall;
    logic dn_stall;

    assign up_stall = stall[STAGE];
    assign dn_stall = stall[STAGE+1];

    // Upstream running with downstream stopped is unreachable; it falls through to PASS.
    always_comb begin
        op = OP_HOLD;
        if (flush) begin
            op = OP_FLUSH;
        end else if (up_stall && !dn_stall) begin
            op = OP_BUBBLE;
        end else if (!up_stall) begin
            op = OP_PASS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid           <= 1'b0;
            out_data            <= BUBBLE;
            out_is_in_delayslot <= 1'b0;
        end else begin
            case (op)
                OP_FLUSH: begin
                    out_valid           <= 1'b0;
                    out_data            <= BUBBLE;
                    out_is_in_delayslot <= 1'b0;
                end
                OP_BUBBLE: begin
                    out_valid <= 1'b0;
                    out_data  <= BUBBLE;
                end
                OP_PASS: begin
                    out_valid           <= in_valid;
                    out_data            <= in_valid ? in_data : BUBBLE;
                    out_is_in_delayslot <= in_next_in_delayslot;
                end
                default: begin
                end
            endcase
        end
    end

    // Counters saturate at all-ones; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (op == OP_BUBBLE && bubble_cnt != {CNT_W{1'b1}}) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
            if (op == OP_FLUSH && flush_cnt != {CNT_W{1'b1}}) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    illegal_stall_combo: assert property (@(posedge clk) disable iff (rst)
        !(!up_stall && dn_stall))
        else $error("pipe_stage_reg: downstream stalled while upstream runs");

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int DATA_W  = 32;
    localparam int LANES   = 4;
    localparam int PW      = DATA_W * LANES;
    localparam int STALL_W = 6;
    localparam int STAGE   = 2;
    localparam int CNT_W   = 4;
    localparam logic [PW-1:0] BUB = {LANES{32'h0000_0013}};

    logic              clk = 1'b0;
    logic              rst;
    logic [STALL_W-1:0] stall;
    logic              flush;
    logic              in_valid;
    logic [PW-1:0]     in_data;
    logic              in_next_in_delayslot;
    logic              out_valid;
    logic [PW-1:0]     out_data;
    logic              out_is_in_delayslot;
    logic              cnt_clr;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .STALL_W(STALL_W),
        .STAGE  (STAGE),
        .BUBBLE (BUB),
        .CNT_W  (CNT_W)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .flush               (flush),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_next_in_delayslot(in_next_in_delayslot),
        .out_valid           (out_valid),
        .out_data            (out_data),
        .out_is_in_delayslot (out_is_in_delayslot),
        .cnt_clr             (cnt_clr),
        .bubble_cnt          (bubble_cnt),
        .flush_cnt           (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [PW-1:0] d,
                           input logic ds, input logic [CNT_W-1:0] bc, input logic [CNT_W-1:0] fc);
        chk({tag, "_valid"}, PW'(out_valid), PW'(v));
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_ds"}, PW'(out_is_in_delayslot), PW'(ds));
        chk({tag, "_bcnt"}, PW'(bubble_cnt), PW'(bc));
        chk({tag, "_fcnt"}, PW'(flush_cnt), PW'(fc));
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; cnt_clr = 1'b0;
        in_valid = 1'b1; in_data = '1; in_next_in_delayslot = 1'b1;
        tick(); tick();
        chk_all("reset", 1'b0, BUB, 1'b0, 4'd0, 4'd0);

        rst = 1'b0; in_next_in_delayslot = 1'b0;
        in_data = {16{8'h11}}; tick();
        chk_all("pass1", 1'b1, {16{8'h11}}, 1'b0, 4'd0, 4'd0);
        in_data = {16{8'h22}}; in_next_in_delayslot = 1'b1; tick();
        chk_all("pass2", 1'b1, {16{8'h22}}, 1'b1, 4'd0, 4'd0);
        in_data = {16{8'h33}}; in_next_in_delayslot = 1'b0; tick();
        chk_all("pass3", 1'b1, {16{8'h33}}, 1'b0, 4'd0, 4'd0);
        in_data = {16{8'h44}}; in_valid = 1'b0; tick();
        chk_all("pass_invalid", 1'b0, BUB, 1'b0, 4'd0, 4'd0);

        in_valid = 1'b1; in_data = {16{8'hAA}}; in_next_in_delayslot = 1'b1; tick();
        chk_all("loadA", 1'b1, {16{8'hAA}}, 1'b1, 4'd0, 4'd0);

        stall = 6'b000111; in_data = {16{8'h55}}; in_next_in_delayslot = 1'b0;
        tick(); tick(); tick();
        chk_all("bubble3", 1'b0, BUB, 1'b1, 4'd3, 4'd0);

        stall = 6'b000000; in_data = {16{8'hAA}}; in_next_in_delayslot = 1'b1; tick();
        chk_all("loadB", 1'b1, {16{8'hAA}}, 1'b1, 4'd3, 4'd0);

        stall = 6'b001111; in_data = {16{8'h55}}; in_next_in_delayslot = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("hold", 1'b1, {16{8'hAA}}, 1'b1, 4'd3, 4'd0);
        end

        stall = 6'b000111; flush = 1'b1; tick();
        chk_all("flush_bubble", 1'b0, BUB, 1'b0, 4'd3, 4'd1);

        stall = 6'b001111; tick();
        chk_all("flush_hold", 1'b0, BUB, 1'b0, 4'd3, 4'd2);

        flush = 1'b0; stall = 6'b000111;
        for (int i = 0; i < 20; i++) tick();
        chk_all("saturate", 1'b0, BUB, 1'b0, 4'd15, 4'd2);

        cnt_clr = 1'b1; tick();
        chk_all("clr_vs_bubble", 1'b0, BUB, 1'b0, 4'd0, 4'd0);
        cnt_clr = 1'b0; tick();
        chk_all("after_clr", 1'b0, BUB, 1'b0, 4'd1, 4'd0);

        stall = 6'b000000; in_valid = 1'b1; in_data = {16{8'h5A}}; in_next_in_delayslot = 1'b1;
        cnt_clr = 1'b1; tick();
        chk_all("clr_keeps_payload", 1'b1, {16{8'h5A}}, 1'b1, 4'd0, 4'd0);
        cnt_clr = 1'b0; flush = 1'b1; tick();
        flush = 1'b0; stall = 6'b000111; tick();
        chk_all("pre_rst", 1'b0, BUB, 1'b0, 4'd1, 4'd1);

        rst = 1'b1; cnt_clr = 1'b1; stall = 6'b000000; in_data = '1; tick();
        chk_all("rst_with_clr", 1'b0, BUB, 1'b0, 4'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline boundary register for the in-order core, replacing the per-stage hand-written registers such as the one between decode and execute.
- Carries an opaque payload of LANES x DATA_W bits.
- Obeys the global stall vector and inserts bubbles when the upstream stage stalls but the downstream one does not.
- Adds a flush input, a valid bit, the delay-slot feedback flag, and saturating bubble/flush event counters for performance monitoring.

Parameters:
- DATA_W, 32, width of one payload lane.
- LANES, 4, number of payload lanes; total payload PW = DATA_W*LANES.
- STALL_W, 6, width of the global stall vector.
- STAGE, 2, index of the upstream stage in the stall vector; STAGE+1 is the downstream stage. Legal range 0..STALL_W-2; elaboration fails otherwise.
- BUBBLE, {PW{1'b0}}, payload value loaded on bubble, flush and reset. Encodes a NOP with write-enable cleared.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stall  in  STALL_W  global stall vector from ctrl; bit i = stage i stopped
- flush  in  1  pipeline flush (exception/redirect) from ctrl
- in_valid  in  1  upstream payload valid
- in_data  in  PW  upstream payload
- in_next_in_delayslot  in  1  decode says the next instruction is in a delay slot
- out_valid  out  1  registered valid
- out_data  out  PW  registered payload
- out_is_in_delayslot  out  1  delay-slot flag fed back to decode
- cnt_clr  in  1  synchronous clear of both counters
- bubble_cnt  out  CNT_W  bubbles inserted
- flush_cnt  out  CNT_W  flushes taken

Behaviour:
- Single clock; all state updates on the rising edge of clk.
- Reset is synchronous and active-high:
  - out_valid=0, out_data=BUBBLE, out_is_in_delayslot=0, bubble_cnt=0, flush_cnt=0.
  - rst mid-stall or mid-flush overrides everything that cycle.
- Decoded each cycle, in strict priority order:
  1. rst
  2. FLUSH: flush=1, regardless of stall.
  3. BUBBLE: stall[STAGE]=1 and stall[STAGE+1]=0.
  4. PASS: stall[STAGE]=0.
  5. HOLD: stall[STAGE]=1 and stall[STAGE+1]=1.
- FLUSH:
  - out_valid<=0, out_data<=BUBBLE, out_is_in_delayslot<=0.
  - flush_cnt increments.
- BUBBLE:
  - out_valid<=0, out_data<=BUBBLE.
  - out_is_in_delayslot holds its value.
  - bubble_cnt increments.
- PASS:
  - out_valid<=in_valid.
  - out_data<=in_valid ? in_data : BUBBLE.
  - out_is_in_delayslot<=in_next_in_delayslot.
- HOLD:
  - All outputs and counters keep their values.
- Latency: 1 cycle from input to output in PASS. No combinational path from any input to any output.
- stall[STAGE]=0 with stall[STAGE+1]=1 is illegal (ctrl never generates it). The block treats it as PASS. Simulation-only assertion flags it.
- Counters:
  - Saturate at all-ones; no wrap.
  - cnt_clr=1 zeroes both counters. It takes priority over an increment in the same cycle but not over rst.
  - cnt_clr does not affect the payload path.
- All lanes behave identically; there is no per-lane enable.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=all-ones -> out_valid=0, out_data=BUBBLE, counters 0 on the cycle after the rst edge.
- Pass: stall=6'b000000, feed in_data=0x11..,0x22..,0x33.. on consecutive cycles with in_valid=1 -> out_data shows each value exactly 1 cycle later, out_valid=1. With in_next_in_delayslot=1 on the second beat -> out_is_in_delayslot=1 only on the second output cycle.
- Bubble: hold stall=6'b000111 (STAGE=2) for 3 cycles -> out_valid=0, out_data=BUBBLE, bubble_cnt=3, out_is_in_delayslot unchanged.
- Hold: stall=6'b001111 after loading 0xAA.. -> out_data stays 0xAA.., out_valid=1, counters unchanged for 4 cycles.
- Flush priority: flush=1 together with stall=6'b000111 -> flush_cnt+1, bubble_cnt unchanged, out_valid=0, out_is_in_delayslot=0.
- Counter saturation/clear: CNT_W=4, 20 bubble cycles -> bubble_cnt=15. Then cnt_clr=1 together with a bubble cycle -> bubble_cnt=0. rst together with cnt_clr -> full reset values.
